piso_shift_tx: RTL and testbench

Parallel-in serial-out transmitter: the launching end of the team's flip-flop/shift-register serial path. A word is accepted over a valid/ready handshake and driven out one bit per strobe on a single registered serial line, with a frame indicator and a completion pulse. It feeds the serial-in capture logic built from the team's D flip-flop primitives and is the counterpart to a SIPO receiver.

---
 rtl/piso_shift_tx_if.sv | 28 ++
 rtl/piso_shift_tx.sv | 94 +++++++++
 tb/tb_piso_shift_tx.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/piso_shift_tx_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | piso_shift_tx_if : load handshake, bit strobe and serial outputs          |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
interface piso_shift_tx_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             shift_en;
  logic             sdata;
  logic             sframe;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, load_data, shift_en,
    input  load_ready, sdata, sframe, busy, done
  );

  modport slave (
    input  load_valid, load_data, shift_en,
    output load_ready, sdata, sframe, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/piso_shift_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | piso_shift_tx : parallel-in serial-out transmitter, one bit per strobe    |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module piso_shift_tx #(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  piso_shift_tx_if.slave   bus
);

  localparam int             CW     = $clog2(WIDTH);
  localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_sdata;
  logic             r_sframe;
  logic             r_done;

  logic             w_first_bit;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_shifted;

  // The register rotates rather than zero-fills; the wrapped bit is never sent.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_first_bit = bus.load_data[WIDTH-1];
      assign w_next_bit  = r_shift[WIDTH-2];
      assign w_shifted   = {r_shift[WIDTH-2:0], r_shift[WIDTH-1]};
    end else begin : g_lsb_first
      assign w_first_bit = bus.load_data[0];
      assign w_next_bit  = r_shift[1];
      assign w_shifted   = {r_shift[0], r_shift[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_sdata  <= IDLE_LEVEL;
      r_sframe <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.load_valid) begin
            r_shift  <= bus.load_data;
            r_cnt    <= '0;
            r_state  <= ST_SHIFT;
            r_sframe <= 1'b1;
            r_sdata  <= w_first_bit;
          end
        end
        ST_SHIFT: begin
          if (bus.shift_en) begin
            if (r_cnt == C_LAST) begin
              r_state  <= ST_IDLE;
              r_sframe <= 1'b0;
              r_sdata  <= IDLE_LEVEL;
              r_done   <= 1'b1;
            end else begin
              r_cnt   <= r_cnt + 1'b1;
              r_shift <= w_shifted;
              r_sdata <= w_next_bit;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.load_ready = (r_state == ST_IDLE);
  assign bus.busy       = (r_state == ST_SHIFT);
  assign bus.sdata      = r_sdata;
  assign bus.sframe     = r_sframe;
  assign bus.done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_piso_shift_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_piso_shift_tx : vector table, corner sequences and random frames       |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_piso_shift_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       sel;
  logic       lv;
  logic       se;
  logic [7:0] ld;

  always #5 clk = ~clk;

  piso_shift_tx_if #(.WIDTH(8)) bus_m ();
  piso_shift_tx_if #(.WIDTH(8)) bus_l ();

  piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
    .clk(clk), .reset(reset), .bus(bus_m.slave)
  );
  piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .bus(bus_l.slave)
  );

  assign bus_m.load_valid = lv & ~sel;
  assign bus_m.load_data  = ld;
  assign bus_m.shift_en   = se & ~sel;
  assign bus_l.load_valid = lv & sel;
  assign bus_l.load_data  = ld;
  assign bus_l.shift_en   = se & sel;

  logic o_sdata, o_sframe, o_busy, o_done, o_ready;
  assign o_sdata  = sel ? bus_l.sdata      : bus_m.sdata;
  assign o_sframe = sel ? bus_l.sframe     : bus_m.sframe;
  assign o_busy   = sel ? bus_l.busy       : bus_m.busy;
  assign o_done   = sel ? bus_l.done       : bus_m.done;
  assign o_ready  = sel ? bus_l.load_ready : bus_m.load_ready;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected bit order as a vector, first transmitted bit at [7].
  function automatic logic [7:0] ref_seq(input logic [7:0] d, input bit msb);
    logic [7:0] s;
    for (int i = 0; i < 8; i++) s[7-i] = msb ? d[7-i] : d[i];
    return s;
  endfunction

  task automatic check_idle(input string tag, input bit exp_done);
    chk({tag, "_done"},   o_done,   exp_done);
    chk({tag, "_sframe"}, o_sframe, 1'b0);
    chk({tag, "_sdata"},  o_sdata,  1'b0);
    chk({tag, "_busy"},   o_busy,   1'b0);
    chk({tag, "_ready"},  o_ready,  1'b1);
  endtask

  // mode: 0 strobe every cycle, 3 strobe every third cycle, 1 random strobe
  task automatic run_frame(input bit msb, input logic [7:0] data, input logic [7:0] exp_seq,
                           input int mode, input bit b2b, input logic [7:0] nxt, input bit poke);
    int  idx;
    int  cyc;
    bit  s;
    sel = ~msb;
    lv  = 1'b1;
    ld  = data;
    se  = 1'b0;
    step();
    lv  = b2b;
    ld  = b2b ? nxt : 8'h00;
    idx = 0;
    cyc = 0;
    forever begin
      chk("frame_sframe", o_sframe, 1'b1);
      chk("frame_sdata",  o_sdata,  exp_seq[7-idx]);
      chk("frame_busy",   o_busy,   1'b1);
      chk("frame_ready",  o_ready,  1'b0);
      chk("frame_done",   o_done,   1'b0);
      if (poke) begin
        lv = (idx == 3);
        ld = 8'hFF;
      end
      case (mode)
        0:       s = 1'b1;
        3:       s = (cyc % 3 == 2);
        default: s = 1'($urandom % 2);
      endcase
      se = s;
      cyc++;
      if (cyc > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL frame_timeout: got %0d cycles required <= 200", cyc);
        break;
      end
      step();
      if (s) begin
        if (idx == 7) break;
        idx++;
      end
    end
    se = 1'b0;
    if (poke) lv = 1'b0;
    check_idle("donecyc", 1'b1);
    if (mode == 3) chk("stall_frame_cycles", 32'(cyc), 32'd24);
    if (!b2b) begin
      step();
      check_idle("gap", 1'b0);
    end
  endtask

  typedef struct {
    bit         msb;
    logic [7:0] data;
    logic [7:0] exp_seq;
    int         mode;
    bit         b2b;
    logic [7:0] nxt;
    bit         poke;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 8'hA5, 8'hA5,       0, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{1'b0, 8'h1E, 8'b01111000, 0, 1'b0, 8'h00, 1'b0};
    tbl[2] = '{1'b1, 8'hC3, 8'hC3,       3, 1'b0, 8'h00, 1'b0};
    tbl[3] = '{1'b1, 8'h0F, 8'h0F,       0, 1'b0, 8'h00, 1'b1};
    tbl[4] = '{1'b1, 8'h0F, 8'h0F,       0, 1'b1, 8'hF0, 1'b0};
    tbl[5] = '{1'b1, 8'hF0, 8'hF0,       0, 1'b0, 8'h00, 1'b0};

    reset = 1'b0;
    sel   = 1'b0;
    lv    = 1'b0;
    se    = 1'b0;
    ld    = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset", 1'b0);
    reset = 1'b1;
    step();

    // Abort a frame with an asynchronous reset between edges.
    lv = 1'b1;
    ld = 8'h3C;
    step();
    lv = 1'b0;
    se = 1'b1;
    step();
    step();
    chk("pre_abort_sframe", o_sframe, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_idle("async_reset", 1'b0);
    se = 1'b0;
    step();
    reset = 1'b1;
    step();
    check_idle("post_release", 1'b0);
    run_frame(1'b1, 8'h3C, 8'h3C, 0, 1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 6; i++)
      run_frame(tbl[i].msb, tbl[i].data, tbl[i].exp_seq, tbl[i].mode,
                tbl[i].b2b, tbl[i].nxt, tbl[i].poke);

    for (int i = 0; i < 24; i++) begin
      logic [7:0] d;
      bit         m;
      d = 8'($urandom);
      m = 1'($urandom % 2);
      run_frame(m, d, ref_seq(d, m), 1, 1'b0, 8'h00, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
